// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// The slave side is the adder; the master side feeds operands and drains results.
interface pipelined_addsub_if #(
  parameter int WIDTH = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, neg
  );
endinterface

// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/sub with carry-in, split into STAGES carry-registered slices.
// One global advance enable stalls the whole pipe; flags are registered with the sum.
module addsub_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
endmodule

module pipelined_addsub #(
  parameter int WIDTH  = 24,
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  pipelined_addsub_if.slave bus
);
  localparam int SW = WIDTH / STAGES;

  logic             adv;
  logic             xfer;
  logic [WIDTH-1:0] a_x;
  logic [WIDTH-1:0] b_x;
  logic             c_x;
  logic [STAGES:1]  vld_pipe;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;

  assign adv  = !vld_pipe[STAGES] | bus.out_ready;
  assign xfer = bus.in_valid & adv;

  // Bubbles carry zeroed operands so nothing undefined ever enters the pipe.
  assign a_x = xfer ? bus.a : '0;
  assign b_x = xfer ? (bus.op[1] ? ~bus.b : bus.b) : '0;
  assign c_x = xfer & (bus.op[1] ? (bus.op[0] ? ~bus.cin : 1'b1)
                                 : (bus.op[0] & bus.cin));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (adv) begin
      vld_pipe[1] <= xfer;
      for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Stage k consumes slice [HI-1:LO]; upper operand bits ride forward, lower
  // result bits accumulate, so a result's slices line up at the last stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SW;
    localparam int W  = (k == STAGES - 1) ? WIDTH - LO : SW;
    localparam int HI = LO + W;

    logic [WIDTH-1:LO] a_i;
    logic [WIDTH-1:LO] b_i;
    logic              c_i;
    logic              c_o;
    logic [W-1:0]      s_sl;
    logic [HI-1:0]     s_nx;

    if (k == 0) begin : g_first
      assign a_i  = a_x;
      assign b_i  = b_x;
      assign c_i  = c_x;
      assign s_nx = s_sl;
    end else begin : g_chain
      assign a_i  = g_st[k-1].g_reg.a_q;
      assign b_i  = g_st[k-1].g_reg.b_q;
      assign c_i  = g_st[k-1].g_reg.c_q;
      assign s_nx = {s_sl, g_st[k-1].g_reg.s_q};
    end

    addsub_slice #(.W(W)) u_slice (
      .a  (a_i[HI-1:LO]),
      .b  (b_i[HI-1:LO]),
      .ci (c_i),
      .s  (s_sl),
      .co (c_o)
    );

    if (k < STAGES - 1) begin : g_reg
      logic [WIDTH-1:HI] a_q;
      logic [WIDTH-1:HI] b_q;
      logic [HI-1:0]     s_q;
      logic              c_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
        end else if (adv) begin
          a_q <= a_i[WIDTH-1:HI];
          b_q <= b_i[WIDTH-1:HI];
          s_q <= s_nx;
          c_q <= c_o;
        end
      end
    end else begin : g_out
      // Carry into the MSB recovered from the MSB sum bit and its operands.
      logic c_msb;
      assign c_msb = a_i[WIDTH-1] ^ b_i[WIDTH-1] ^ s_sl[W-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
          neg_q  <= 1'b0;
        end else if (adv) begin
          sum_q  <= s_nx;
          cout_q <= c_o;
          ovf_q  <= c_msb ^ c_o;
          zero_q <= ~|s_nx;
          neg_q  <= s_nx[WIDTH-1];
        end
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Randomised and directed bench for pipelined_addsub against an arithmetic model,
// plus a sweep of other WIDTH/STAGES builds running alongside the main instance.
module tb_pipelined_addsub;
  localparam int MW = 24;
  localparam int MS = 3;

  logic clk      = 1'b0;
  logic rst_n    = 1'b1;
  logic sw_rst_n = 1'b1;
  int   n_chk    = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  typedef struct {
    longint sum;
    bit     cout;
    bit     ovf;
    bit     zero;
    bit     neg;
  } res_t;

  function automatic void check(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endfunction

  // Integer-level reference: unsigned result for carry, signed result for overflow.
  function automatic res_t model(int w, logic [1:0] op, longint a, longint b, logic cin);
    res_t   r;
    longint m, sa, sb, ci, u, s;
    m  = longint'(1) << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    ci = op[0] ? longint'(cin) : 0;
    if (!op[1]) begin
      u      = a + b + ci;
      s      = sa + sb + ci;
      r.cout = (u >= m);
    end else begin
      u      = a - b - ci;
      s      = sa - sb - ci;
      r.cout = (a >= b + ci);
    end
    r.sum  = u & (m - 1);
    r.ovf  = (s < -(m / 2)) || (s >= m / 2);
    r.zero = (r.sum == 0);
    r.neg  = (r.sum >= m / 2);
    return r;
  endfunction

  // ---------------- main instance (24,3) ----------------
  pipelined_addsub_if #(.WIDTH(MW)) bus ();
  pipelined_addsub #(.WIDTH(MW), .STAGES(MS)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  res_t slot_r[MS];
  bit   slot_v[MS];

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MS; i++) slot_v[i] = 1'b0;
    end else begin
      bit adv_m;
      adv_m = !slot_v[MS-1] || bus.out_ready;
      check("in_ready", bus.in_ready, adv_m);
      check("out_valid", bus.out_valid, slot_v[MS-1]);
      if (slot_v[MS-1]) begin
        check("sum", bus.sum, slot_r[MS-1].sum);
        check("cout", bus.cout, slot_r[MS-1].cout);
        check("ovf", bus.ovf, slot_r[MS-1].ovf);
        check("zero", bus.zero, slot_r[MS-1].zero);
        check("neg", bus.neg, slot_r[MS-1].neg);
      end
      if (adv_m) begin
        for (int i = MS - 1; i > 0; i--) begin
          slot_v[i] = slot_v[i-1];
          slot_r[i] = slot_r[i-1];
        end
        slot_v[0] = bus.in_valid;
        slot_r[0] = model(MW, bus.op, bus.a, bus.b, bus.cin);
      end
    end
  end

  function automatic logic [MW-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 24'h000000;
      1:       return 24'hFFFFFF;
      2:       return 24'h800000;
      3:       return 24'h7FFFFF;
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic send(input logic [1:0] op, input logic [MW-1:0] a, input logic [MW-1:0] b,
                      input logic cin);
    int t;
    t = 0;
    bus.op = op; bus.a = a; bus.b = b; bus.cin = cin; bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("send_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic directed(input string nm, input logic [1:0] op, input logic [MW-1:0] a,
                          input logic [MW-1:0] b, input logic cin, input logic [MW-1:0] es,
                          input bit ec, input bit eo, input bit ez, input bit en);
    int lat;
    send(op, a, b, cin);
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
    check({nm, "_lat"}, lat, MS);
    check({nm, "_sum"}, bus.sum, es);
    check({nm, "_cout"}, bus.cout, ec);
    check({nm, "_ovf"}, bus.ovf, eo);
    check({nm, "_zero"}, bus.zero, ez);
    check({nm, "_neg"}, bus.neg, en);
    @(posedge clk);
    #1;
  endtask

  // ---------------- sweep instances ----------------
  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int W = (g == 2) ? 8 : (g == 3) ? 32 : 24;
    localparam int S = (g == 0) ? 1 : (g == 1) ? 5 : (g == 2) ? 8 : 4;

    pipelined_addsub_if #(.WIDTH(W)) sb ();
    pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_sw (
      .clk   (clk),
      .rst_n (sw_rst_n),
      .bus   (sb.slave)
    );

    bit   done = 1'b0;
    int   cyc  = 0;
    int   nres = 0;
    int   due_q[$];
    res_t res_q[$];

    initial begin
      sb.in_valid = 1'b0; sb.out_ready = 1'b1;
      sb.a = '0; sb.b = '0; sb.cin = 1'b0; sb.op = 2'b00;
      @(posedge sw_rst_n);
      @(posedge clk);
      #1;
      for (int i = 0; i < 41; i++) begin
        sb.in_valid = (i == 0) || ($urandom_range(0, 3) != 0);
        sb.op       = (i == 0) ? 2'b00 : 2'($urandom);
        sb.a        = (i == 0) ? '1 : W'($urandom);
        sb.b        = (i == 0) ? W'(1) : W'($urandom);
        sb.cin      = 1'($urandom);
        @(posedge clk);
        #1;
      end
      sb.in_valid = 1'b0;
      repeat (S + 3) @(posedge clk);
      done = 1'b1;
    end

    always @(negedge clk) begin
      if (sw_rst_n) begin
        bit exp_v;
        cyc++;
        exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
        check($sformatf("sw%0d_in_ready", g), sb.in_ready, 1);
        check($sformatf("sw%0d_out_valid", g), sb.out_valid, exp_v);
        if (exp_v) begin
          check($sformatf("sw%0d_sum", g), sb.sum, res_q[0].sum);
          check($sformatf("sw%0d_cout", g), sb.cout, res_q[0].cout);
          check($sformatf("sw%0d_ovf", g), sb.ovf, res_q[0].ovf);
          check($sformatf("sw%0d_zero", g), sb.zero, res_q[0].zero);
          check($sformatf("sw%0d_neg", g), sb.neg, res_q[0].neg);
          if (nres == 0) begin
            check($sformatf("sw%0d_wrap_sum", g), sb.sum, 0);
            check($sformatf("sw%0d_wrap_cout", g), sb.cout, 1);
            check($sformatf("sw%0d_wrap_zero", g), sb.zero, 1);
          end
          nres++;
          void'(due_q.pop_front());
          void'(res_q.pop_front());
        end
        if (sb.in_valid) begin
          due_q.push_back(cyc + S);
          res_q.push_back(model(W, sb.op, sb.a, sb.b, sb.cin));
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int sent, cyc, nv, t;
    bit acc;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.op = 2'b00;
    #1 rst_n = 1'b0; sw_rst_n = 1'b0;
    #2;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_sum", bus.sum, 0);
    check("reset_cout", bus.cout, 0);
    check("reset_ovf", bus.ovf, 0);
    check("reset_zero", bus.zero, 0);
    check("reset_neg", bus.neg, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1; sw_rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("add_wrap",  2'b00, 24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1, 0, 1, 0);
    directed("sub_ovf",   2'b10, 24'h800000, 24'h000001, 1'b0, 24'h7FFFFF, 1, 1, 0, 0);
    directed("sbb_brw",   2'b11, 24'h000005, 24'h000005, 1'b1, 24'hFFFFFF, 0, 0, 0, 1);
    directed("adc_chain", 2'b01, 24'h7FFFFF, 24'h000000, 1'b1, 24'h800000, 0, 1, 0, 1);
    directed("add_nocin", 2'b00, 24'h000005, 24'h000003, 1'b1, 24'h000008, 0, 0, 0, 0);

    // Back-to-back random ops with a randomly stalling consumer.
    sent = 0; cyc = 0;
    bus.op = 2'($urandom); bus.a = pick(); bus.b = pick(); bus.cin = 1'($urandom);
    bus.in_valid = 1'b1; bus.out_ready = 1'($urandom);
    while (sent < 100 && cyc < 2000) begin
      @(negedge clk);
      acc = bus.in_ready;
      cyc++;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        if (sent < 100) begin
          bus.op = 2'($urandom); bus.a = pick(); bus.b = pick(); bus.cin = 1'($urandom);
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = 1'($urandom);
    end
    check("rand_sent", sent, 100);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (MS + 2) @(posedge clk);
    #1;

    // Reset with three ops in flight: nothing may emerge afterwards.
    bus.out_ready = 1'b0;
    send(2'b00, 24'h123456, 24'h111111, 1'b0);
    send(2'b10, 24'h00ABCD, 24'h000001, 1'b0);
    send(2'b01, 24'h0F0F0F, 24'h010101, 1'b1);
    check("rst_pre_valid", bus.out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_zero", bus.zero, 0);
    check("rst_neg", bus.neg, 0);
    @(posedge clk);
    #2 rst_n = 1'b1; bus.out_ready = 1'b1;
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) nv++;
    end
    check("rst_no_emerge", nv, 0);

    t = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check("sweep_done", (t < 2000), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
